pg_idle_policy: RTL

- Upstream policy stage for the power gating controller. Sits between the gated block's activity and wake signals and the controller's request/ack handshake.
- Counts consecutive idle cycles of the powered domain and issues power_off_req once the idle threshold is reached.
- Latches wake events and issues power_on_req after a minimum off-residency.
- Flags sticky handshake timeouts when the controller fails to acknowledge a request.

---
 rtl/pg_idle_policy.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pg_idle_policy.sv
// Power-gating idle policy: idle-count power-down, wake latching with
// minimum off residency, and sticky handshake timeout detection.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   policy_en         allow automatic power-down
//   activity          gated block busy this cycle
//   wake_req          wake event (pulse or level)
//   power_on_ack      controller ack for power_on_req
//   power_off_ack     controller ack for power_off_req
//   power_on_req      request power-up (state REQ_ON)
//   power_off_req     request power-down (state REQ_OFF)
//   domain_ready      domain powered and usable (state ON)
//   wake_pending      wake latched, not yet serviced
//   timeout_err       sticky: an ack took too long
//   state_o           OFF=0, REQ_ON=1, ON=2, REQ_OFF=3
module pg_idle_policy #(
  parameter int IDLE_THRESH = 16,
  parameter int MIN_OFF     = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       policy_en,
  input  logic       activity,
  input  logic       wake_req,
  input  logic       power_on_ack,
  input  logic       power_off_ack,
  output logic       power_on_req,
  output logic       power_off_req,
  output logic       domain_ready,
  output logic       wake_pending,
  output logic       timeout_err,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_REQ_ON  = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_REQ_OFF = 2'd3;

  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_THRESH - 1);
  localparam logic [CNT_W-1:0] OFF_MIN =
    CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_nx;
  logic [CNT_W-1:0] off_cnt;
  logic [CNT_W-1:0] off_nx;
  logic [CNT_W-1:0] ack_cnt;
  logic [CNT_W-1:0] ack_nx;
  logic             wake_nx;
  logic             to_nx;

  logic res_ok;
  logic idle_cyc;
  logic in_req;
  logic ack_hit;

  // off_cnt==0 only exists after reset (entry from REQ_OFF loads 1),
  // so it marks residency as already satisfied.
  assign res_ok   = (off_cnt == '0) ||
                    (off_cnt >= OFF_MIN);
  assign idle_cyc = !activity && !wake_req &&
                    policy_en;
  assign in_req   = (state == S_REQ_ON) ||
                    (state == S_REQ_OFF);
  assign ack_hit  = ((state == S_REQ_ON) &&
                     power_on_ack) ||
                    ((state == S_REQ_OFF) &&
                     power_off_ack);

  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    off_nx   = off_cnt;
    ack_nx   = ack_cnt;
    wake_nx  = wake_pending;
    to_nx    = timeout_err;

    // Set on the edge where the wait reaches ACK_TIMEOUT cycles.
    if (in_req && !ack_hit &&
        (ack_cnt >= ACK_LAST)) begin
      to_nx = 1'b1;
    end

    case (state)
      S_OFF: begin
        if ((off_cnt != '0) &&
            (off_cnt < OFF_MIN)) begin
          off_nx = off_cnt + 1'b1;
        end
        if (wake_req) begin
          wake_nx = 1'b1;
        end
        if ((wake_pending || wake_req) &&
            res_ok) begin
          state_nx = S_REQ_ON;
          ack_nx   = '0;
        end
      end
      S_REQ_ON: begin
        if (power_on_ack) begin
          state_nx = S_ON;
          wake_nx  = 1'b0;
          idle_nx  = '0;
          ack_nx   = '0;
        end else if (ack_cnt != CNT_MAX) begin
          ack_nx = ack_cnt + 1'b1;
        end
      end
      S_ON: begin
        if (!idle_cyc) begin
          idle_nx = '0;
        end else if (idle_cnt >= IDLE_LAST) begin
          state_nx = S_REQ_OFF;
          idle_nx  = '0;
          ack_nx   = '0;
        end else begin
          idle_nx = idle_cnt + 1'b1;
        end
      end
      S_REQ_OFF: begin
        // No abort here: the controller may be saving state.
        if (wake_req || activity) begin
          wake_nx = 1'b1;
        end
        if (power_off_ack) begin
          state_nx = S_OFF;
          off_nx   = CNT_W'(1);
          ack_nx   = '0;
        end else if (ack_cnt != CNT_MAX) begin
          ack_nx = ack_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_OFF;
      idle_cnt      <= '0;
      off_cnt       <= '0;
      ack_cnt       <= '0;
      wake_pending  <= 1'b0;
      timeout_err   <= 1'b0;
      power_on_req  <= 1'b0;
      power_off_req <= 1'b0;
      domain_ready  <= 1'b0;
    end else begin
      state         <= state_nx;
      idle_cnt      <= idle_nx;
      off_cnt       <= off_nx;
      ack_cnt       <= ack_nx;
      wake_pending  <= wake_nx;
      timeout_err   <= to_nx;
      power_on_req  <= (state_nx == S_REQ_ON);
      power_off_req <= (state_nx == S_REQ_OFF);
      domain_ready  <= (state_nx == S_ON);
    end
  end

  assign state_o = state;

endmodule
